// File: rtl/seq_mult.sv
// seq_mult: iterative shift-add multiplier that retires one multiplier bit per clock.
// Signed operands are reduced to magnitudes on entry; the product sign is restored on exit.
module seq_mult #(
  parameter int W = 18
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           start,
  input  logic           sign_mode,
  input  logic [W-1:0]   dataa,
  input  logic [W-1:0]   datab,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] result
);

  localparam int PW = 2 * W;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  mca_q;
  logic [W-1:0]  mcb_q;
  logic [PW-1:0] acc_q;
  logic [CW-1:0] cnt_q;
  logic          neg_q;
  logic          last_bit;

  // W unsigned bits hold the magnitude of the most negative operand exactly.
  function automatic logic [W-1:0] magnitude(input logic [W-1:0] v, input logic is_signed);
    return (is_signed && v[W-1]) ? (~v + W'(1)) : v;
  endfunction

  function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] v, input logic neg);
    return neg ? (~v + PW'(1)) : v;
  endfunction

  assign last_bit = (cnt_q == CW'(W - 1));
  assign busy     = (state_q != IDLE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mca_q  <= '0;
      mcb_q  <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      neg_q  <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mca_q <= magnitude(dataa, sign_mode);
            mcb_q <= magnitude(datab, sign_mode);
            neg_q <= sign_mode & (dataa[W-1] ^ datab[W-1]);
            acc_q <= '0;
            cnt_q <= '0;
          end
        end
        RUN: begin
          if (mcb_q[cnt_q]) acc_q <= acc_q + ({{W{1'b0}}, mca_q} << cnt_q);
          cnt_q <= cnt_q + CW'(1);
        end
        FINISH: begin
          result <= apply_sign(acc_q, neg_q);
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult.sv
// Bench for seq_mult: timing/product reference model checked every cycle,
// directed corner operations with literal expectations, then randomized traffic.
module tb_seq_mult;

  localparam int W = 18;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic           start = 1'b0;
  logic           sign_mode = 1'b0;
  logic [W-1:0]   dataa = '0;
  logic [W-1:0]   datab = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;

  int n_chk = 0;
  int n_fail = 0;

  seq_mult #(.W(W)) dut (
    .CLK(CLK), .RST(RST), .start(start), .sign_mode(sign_mode),
    .dataa(dataa), .datab(datab), .busy(busy), .done(done), .result(result)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] ref_prod(input logic sm, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    longint sa, sb;
    logic [63:0] p;
    sa = sm ? longint'($signed(a)) : longint'(a);
    sb = sm ? longint'($signed(b)) : longint'(b);
    p  = sa * sb;
    return p[2*W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v;
    case ($urandom_range(0, 4))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b1, {(W-1){1'b0}}};
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  // Reference: an accepted request completes W+1 edges later; requests are
  // only accepted when no operation is outstanding.
  logic           m_active = 1'b0;
  logic           m_done = 1'b0;
  logic [2*W-1:0] m_result = '0;
  logic [2*W-1:0] m_pend = '0;
  int             m_left = 0;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_result <= '0;
      m_left   <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_active) begin
        if (m_left == 1) begin
          m_result <= m_pend;
          m_done   <= 1'b1;
          m_active <= 1'b0;
        end else begin
          m_left <= m_left - 1;
        end
      end else if (start) begin
        m_active <= 1'b1;
        m_left   <= W + 1;
        m_pend   <= ref_prod(sign_mode, dataa, datab);
      end
    end
  end

  always @(negedge CLK) begin
    chk("busy", busy, m_active);
    chk("done", done, m_done);
    chk("result", result, m_result);
  end

  // Called and returning at negedge+1. second_at>0 issues a 7x7 start sampled at that edge.
  task automatic op(input string name, input logic sm, input logic [W-1:0] a,
                    input logic [W-1:0] b, input logic [2*W-1:0] exp, input int second_at);
    int k = 0;
    int nbusy = 0;
    int extra = 0;
    logic seen = 1'b0;
    sign_mode = sm; dataa = a; datab = b; start = 1'b1;
    while (!seen && k < 3 * W) begin
      @(negedge CLK);
      k++;
      if (busy) nbusy++;
      if (done) seen = 1'b1;
      #1;
      start = (second_at != 0 && k == second_at);
      if (start) begin
        dataa = W'(7); datab = W'(7); sign_mode = 1'b0;
      end else begin
        dataa = W'($urandom); datab = W'($urandom); sign_mode = 1'($urandom);
      end
    end
    start = 1'b0;
    chk({name, " done seen"}, seen, 1);
    chk({name, " latency"}, k, W + 2);
    chk({name, " busy cycles"}, nbusy, W + 1);
    chk({name, " result"}, result, exp);
    repeat (W + 4) begin
      @(negedge CLK);
      if (done) extra++;
    end
    #1;
    chk({name, " extra done"}, extra, 0);
    chk({name, " result held"}, result, exp);
  endtask

  initial begin
    int k, d1, d2, n;
    #1 RST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset result", result, 0);
    #1 RST = 1'b1;

    op("u3x5", 1'b0, 18'd3, 18'd5, 36'd15, 0);
    op("umax", 1'b0, 18'h3FFFF, 18'h3FFFF, 36'hF_FFF8_0001, 0);
    op("s-3x5", 1'b1, 18'h3FFFD, 18'd5, 36'hF_FFFF_FFF1, 0);
    op("smin", 1'b1, 18'h20000, 18'h20000, 36'h4_0000_0000, 0);
    op("s-1x-1", 1'b1, 18'h3FFFF, 18'h3FFFF, 36'd1, 0);
    op("start while busy", 1'b0, 18'd3, 18'd5, 36'd15, 5);

    // Reset in the middle of an operation.
    sign_mode = 1'b0; dataa = 18'd3; datab = 18'd5; start = 1'b1;
    @(negedge CLK); #1 start = 1'b0;
    repeat (10) @(negedge CLK);
    chk("mid-op busy", busy, 1);
    #1 RST = 1'b0;
    #1;
    chk("async rst busy", busy, 0);
    chk("async rst done", done, 0);
    chk("async rst result", result, 0);
    repeat (2) @(negedge CLK);
    #1 RST = 1'b1;
    op("after reset 2x2", 1'b0, 18'd2, 18'd2, 36'd4, 0);

    // Back-to-back with start held high.
    sign_mode = 1'b0; dataa = 18'd3; datab = 18'd5; start = 1'b1;
    k = 0; d1 = -1; d2 = -1;
    while (d2 < 0 && k < 60) begin
      @(negedge CLK);
      k++;
      if (done) begin
        if (d1 < 0) begin
          d1 = k;
          chk("b2b first result", result, 15);
        end else begin
          d2 = k;
          chk("b2b second result", result, 42);
        end
      end
      #1;
      if (k == 1) begin dataa = 18'd6; datab = 18'd7; end
      if (d2 >= 0) start = 1'b0;
    end
    start = 1'b0;
    chk("b2b done spacing", 64'(d2 - d1), 20);
    n = 0;
    while (busy && n < 3 * W) begin @(negedge CLK); n++; end
    #1;

    // Randomized traffic, occasional held start, operand churn and mid-op resets.
    for (int i = 0; i < 40; i++) begin
      int gap, hold;
      gap  = $urandom_range(0, 3);
      hold = $urandom_range(1, 3);
      repeat (gap) begin @(negedge CLK); #1; end
      sign_mode = 1'($urandom); dataa = rand_op(); datab = rand_op(); start = 1'b1;
      for (int j = 0; j < hold; j++) begin
        @(negedge CLK); #1;
        dataa = rand_op(); datab = rand_op(); sign_mode = 1'($urandom);
      end
      start = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(0, W)) @(negedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        #1 RST = 1'b1;
      end
      n = 0;
      while (busy && n < 3 * W) begin @(negedge CLK); n++; end
      #1;
      chk("random op returns idle", busy, 0);
    end

    repeat (3) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1);
  end

endmodule
